// File: rtl/imem_if.sv
// Instruction-memory fetch bus: req/gnt address handshake plus an in-order rvalid response channel.
interface imem_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: issues bundle fetches, tracks in-flight addresses, buffers
// returned bundles and drives the IF/ID register; redirects squash stale responses.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_stall,
  input  logic          IF_flush,
  input  logic [1:0]    pcSrc,
  input  logic [31:0]   br_base_pc,
  input  logic [31:0]   br_offset,
  input  logic [31:0]   jmp_base_pc,
  input  logic [31:0]   jmp_offset,
  imem_if.master        imem,
  output logic [15:0]   p1_aluInstr,
  output logic [15:0]   p1_memInstr,
  output logic [31:0]   p1_pc,
  output logic          p1_valid
);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW:0] CAP = (CW+1)'(BUF_DEPTH);

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding, buf_count, drop_cnt;

  // Address queue shadows requests in flight so each response gets its PC.
  logic [31:0]   aq_mem [BUF_DEPTH];
  logic [PW-1:0] aq_wp, aq_rp;
  logic [31:0]   bq_data [BUF_DEPTH];
  logic [31:0]   bq_addr [BUF_DEPTH];
  logic [PW-1:0] bq_wp, bq_rp;

  logic        redirect, flush, advance, grant, rsp, keep, bypass, bq_push, bq_pop, bq_empty;
  logic [31:0] target, aq_head;

  assign redirect = (pcSrc == 2'b01) | (pcSrc == 2'b10);

  always_comb begin
    target      = (pcSrc == 2'b10) ? jmp_base_pc + jmp_offset : br_base_pc + br_offset;
    target[1:0] = 2'b00;
  end

  assign imem.imem_req  = reset & ~redirect & (({1'b0, outstanding} + {1'b0, buf_count}) < CAP);
  assign imem.imem_addr = fetch_pc;

  assign grant    = imem.imem_req & imem.imem_gnt;
  assign rsp      = imem.imem_rvalid & (outstanding != '0);
  assign keep     = rsp & (drop_cnt == '0);
  assign flush    = IF_flush | redirect;
  assign advance  = ~flush & ~id_stall;
  assign bq_empty = (buf_count == '0);
  assign bypass   = advance & bq_empty & keep;
  assign bq_pop   = advance & ~bq_empty;
  assign bq_push  = keep & ~redirect & ~bypass;
  assign aq_head  = aq_mem[aq_rp];

  always_ff @(posedge clk) begin
    if (grant) aq_mem[aq_wp] <= fetch_pc;
    if (bq_push) begin
      bq_data[bq_wp] <= imem.imem_rdata;
      bq_addr[bq_wp] <= aq_head;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      aq_wp       <= '0;
      aq_rp       <= '0;
      bq_wp       <= '0;
      bq_rp       <= '0;
      outstanding <= '0;
      buf_count   <= '0;
      drop_cnt    <= '0;
      p1_aluInstr <= 16'h0000;
      p1_memInstr <= 16'h0000;
      p1_pc       <= 32'h0;
      p1_valid    <= 1'b0;
    end else begin
      if (grant) aq_wp <= nxt(aq_wp);
      if (rsp)   aq_rp <= nxt(aq_rp);
      outstanding <= outstanding + CW'(grant) - CW'(rsp);

      // Everything still in flight after this edge belongs to the old path.
      if (redirect) begin
        fetch_pc  <= target;
        drop_cnt  <= outstanding - CW'(rsp);
        bq_wp     <= '0;
        bq_rp     <= '0;
        buf_count <= '0;
      end else begin
        if (grant) fetch_pc <= fetch_pc + 32'd4;
        if (rsp && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        if (bq_push) bq_wp <= nxt(bq_wp);
        if (bq_pop)  bq_rp <= nxt(bq_rp);
        buf_count <= buf_count + CW'(bq_push) - CW'(bq_pop);
      end

      if (flush) begin
        p1_aluInstr <= 16'h0000;
        p1_memInstr <= 16'h0000;
        p1_valid    <= 1'b0;
      end else if (!id_stall) begin
        if (bq_pop) begin
          p1_aluInstr <= bq_data[bq_rp][15:0];
          p1_memInstr <= bq_data[bq_rp][31:16];
          p1_pc       <= bq_addr[bq_rp];
          p1_valid    <= 1'b1;
        end else if (bypass) begin
          p1_aluInstr <= imem.imem_rdata[15:0];
          p1_memInstr <= imem.imem_rdata[31:16];
          p1_pc       <= aq_head;
          p1_valid    <= 1'b1;
        end else begin
          p1_aluInstr <= 16'h0000;
          p1_memInstr <= 16'h0000;
          p1_valid    <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: in-order memory responder plus hand-computed checks.
module tb_if_fetch_stage;
  logic        clk = 1'b0;
  logic        reset, id_stall, IF_flush;
  logic [1:0]  pcSrc;
  logic [31:0] br_base_pc, br_offset, jmp_base_pc, jmp_offset;
  logic [15:0] p1_aluInstr, p1_memInstr;
  logic [31:0] p1_pc;
  logic        p1_valid;

  imem_if bus();

  if_fetch_stage #(.RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .id_stall(id_stall), .IF_flush(IF_flush), .pcSrc(pcSrc),
    .br_base_pc(br_base_pc), .br_offset(br_offset), .jmp_base_pc(jmp_base_pc),
    .jmp_offset(jmp_offset), .imem(bus), .p1_aluInstr(p1_aluInstr),
    .p1_memInstr(p1_memInstr), .p1_pc(p1_pc), .p1_valid(p1_valid)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          grants = 0;
  logic        hold = 1'b0, stale_rv = 1'b0, gnt_en = 1'b1;
  logic        req_s;
  logic [31:0] addr_s;
  logic [31:0] pend [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive response/gnt at negedge, record the request the DUT presents, sample after posedge.
  task automatic step();
    @(negedge clk);
    bus.imem_gnt = gnt_en;
    if (stale_rv) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hDEAD_BEEF;
    end else if (!hold && pend.size() > 0) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = {pend[0][15:0], ~pend[0][15:0]};
      void'(pend.pop_front());
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
    end
    #1;
    req_s  = bus.imem_req;
    addr_s = bus.imem_addr;
    if (bus.imem_req && bus.imem_gnt) begin
      pend.push_back(bus.imem_addr);
      grants++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int g0;
    reset = 1'b0; id_stall = 1'b0; IF_flush = 1'b0; pcSrc = 2'b00;
    br_base_pc = '0; br_offset = '0; jmp_base_pc = '0; jmp_offset = '0;
    bus.imem_gnt = 1'b1; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;

    step(); step();
    chk("rst_req", {31'h0, req_s}, 32'h0);
    chk("rst_valid", {31'h0, p1_valid}, 32'h0);
    chk("rst_pc", p1_pc, 32'h0);
    chk("rst_alu", {16'h0, p1_aluInstr}, 32'h0);
    chk("rst_mem", {16'h0, p1_memInstr}, 32'h0);

    // streaming
    reset = 1'b1;
    step();
    chk("s0_req", {31'h0, req_s}, 32'h1);
    chk("s0_addr", addr_s, 32'h0);
    chk("s0_valid", {31'h0, p1_valid}, 32'h0);
    step();
    chk("s1_addr", addr_s, 32'h4);
    chk("s1_pc", p1_pc, 32'h0);
    chk("s1_alu", {16'h0, p1_aluInstr}, 32'hFFFF);
    chk("s1_mem", {16'h0, p1_memInstr}, 32'h0);
    chk("s1_valid", {31'h0, p1_valid}, 32'h1);
    for (int k = 2; k <= 5; k++) begin
      step();
      chk("stream_addr", addr_s, 32'(4 * k));
      chk("stream_pc", p1_pc, 32'(4 * (k - 1)));
      chk("stream_valid", {31'h0, p1_valid}, 32'h1);
    end
    chk("stream_alu", {16'h0, p1_aluInstr}, 32'hFFEF);

    // id_stall for 4 cycles
    id_stall = 1'b1;
    g0 = grants;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("stall_pc", p1_pc, 32'h10);
      chk("stall_valid", {31'h0, p1_valid}, 32'h1);
      if (k >= 2) chk("stall_req", {31'h0, req_s}, 32'h0);
    end
    chk("stall_grants_le2", {31'h0, (grants - g0) <= 2}, 32'h1);
    id_stall = 1'b0;
    step(); chk("rel_pc0", p1_pc, 32'h14);
    step(); chk("rel_pc1", p1_pc, 32'h18); chk("rel_addr", addr_s, 32'h1C);
    step(); chk("rel_pc2", p1_pc, 32'h1C);
    step(); chk("rel_pc3", p1_pc, 32'h20); chk("rel_valid", {31'h0, p1_valid}, 32'h1);

    // branch with two responses outstanding
    hold = 1'b1;
    step(); chk("pre_br_req", {31'h0, req_s}, 32'h1);
    pcSrc = 2'b01; br_base_pc = 32'h100; br_offset = 32'h10;
    step();
    chk("br_req", {31'h0, req_s}, 32'h0);
    chk("br_valid", {31'h0, p1_valid}, 32'h0);
    pcSrc = 2'b00; hold = 1'b0;
    step(); chk("drop0_valid", {31'h0, p1_valid}, 32'h0);
    step();
    chk("drop1_valid", {31'h0, p1_valid}, 32'h0);
    chk("br_tgt_req", {31'h0, req_s}, 32'h1);
    chk("br_tgt_addr", addr_s, 32'h110);
    step();
    chk("br_p1_pc", p1_pc, 32'h110);
    chk("br_p1_valid", {31'h0, p1_valid}, 32'h1);
    chk("br_p1_alu", {16'h0, p1_aluInstr}, 32'hFEEF);

    // jump wrapping to zero
    pcSrc = 2'b10; jmp_base_pc = 32'hFFFF_FFFC; jmp_offset = 32'h4;
    step();
    chk("jmp_req", {31'h0, req_s}, 32'h0);
    chk("jmp_valid", {31'h0, p1_valid}, 32'h0);
    pcSrc = 2'b00;
    step(); chk("jmp_addr0", addr_s, 32'h0);
    step(); chk("jmp_addr1", addr_s, 32'h4); chk("jmp_pc0", p1_pc, 32'h0);
    step(); chk("jmp_addr2", addr_s, 32'h8); chk("jmp_pc1", p1_pc, 32'h4);
    step(); chk("pre_fl_pc", p1_pc, 32'h8);

    // IF_flush alone
    IF_flush = 1'b1;
    step();
    chk("fl_valid", {31'h0, p1_valid}, 32'h0);
    chk("fl_alu", {16'h0, p1_aluInstr}, 32'h0);
    chk("fl_mem", {16'h0, p1_memInstr}, 32'h0);
    chk("fl_addr", addr_s, 32'h10);
    IF_flush = 1'b0;
    step(); chk("fl_next_pc", p1_pc, 32'hC); chk("fl_next_valid", {31'h0, p1_valid}, 32'h1);
    step(); chk("fl_addr2", addr_s, 32'h14); chk("fl_pc2", p1_pc, 32'h10);

    // reset mid-transfer, stale responses afterwards
    hold = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("mid_rst_req", {31'h0, req_s}, 32'h0);
    pend.delete();
    hold = 1'b0; reset = 1'b1; gnt_en = 1'b0; stale_rv = 1'b1;
    step(); chk("stale0_valid", {31'h0, p1_valid}, 32'h0);
    step();
    chk("stale1_valid", {31'h0, p1_valid}, 32'h0);
    chk("stale_req", {31'h0, req_s}, 32'h1);
    chk("stale_addr", addr_s, 32'h0);
    stale_rv = 1'b0; gnt_en = 1'b1;
    step(); chk("post_rst_valid", {31'h0, p1_valid}, 32'h0); chk("post_rst_addr", addr_s, 32'h0);
    step();
    chk("post_rst_pc", p1_pc, 32'h0);
    chk("post_rst_alu", {16'h0, p1_aluInstr}, 32'hFFFF);
    chk("post_rst_p1v", {31'h0, p1_valid}, 32'h1);
    chk("post_rst_addr1", addr_s, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the dual-slot VLIW pipeline.
- Requests 32-bit bundles from instruction memory over a req/gnt + rvalid interface, buffers returned bundles and drives the IF/ID register (p1_aluInstr, p1_memInstr, p1_pc) consumed by the decode stage.
- Owns the fetch PC and applies pcSrc redirects and IF_flush from decode/control, discarding in-flight responses made stale by a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BUF_DEPTH, 2, bundle buffer entries; also the cap on outstanding-plus-buffered bundles (1..4).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- id_stall  in  1  hold the p1 register (hazard stall).
- IF_flush  in  1  kill the bundle in p1 next cycle.
- pcSrc  in  2  00 sequential, 01 branch, 10 jump, 11 treated as 00.
- br_base_pc  in  32  base PC for branch target.
- br_offset  in  32  pre-shifted sign-extended branch offset.
- jmp_base_pc  in  32  base PC for jump target.
- jmp_offset  in  32  pre-shifted sign-extended jump offset.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch byte address; always a multiple of 4.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; responses return in order.
- imem_rdata  in  32  bundle: [31:16] MEM-slot instruction, [15:0] ALU-slot instruction.
- p1_aluInstr  out  16  ALU-slot instruction to decode.
- p1_memInstr  out  16  MEM-slot instruction to decode.
- p1_pc  out  32  address of the bundle in p1.
- p1_valid  out  1  p1 holds a real bundle.

Behaviour:
- Reset (reset==0 at a clock edge):
  - fetch_pc = RESET_PC.
  - p1_aluInstr, p1_memInstr = 16'h0000 (NOP); p1_pc = 0; p1_valid = 0.
  - Buffer empty; outstanding = 0; drop_cnt = 0.
  - imem_req = 0 while reset is low.
  - Reset mid-transfer abandons all state; responses arriving after reset release are treated as unsolicited.
- Redirect: redirect = (pcSrc==01 | pcSrc==10).
  - Target = br_base_pc + br_offset (01) or jmp_base_pc + jmp_offset (10), computed mod 2^32. Bits [1:0] of the target are forced to 0.
- Request:
  - imem_req = reset & ~redirect & (outstanding + buf_count < BUF_DEPTH).
  - imem_addr = fetch_pc.
  - On req & gnt: fetch_pc += 4 (wraps at 2^32); push fetch_pc into the in-order address queue; outstanding += 1.
  - Without gnt, req and addr are held stable unless a redirect occurs.
- Response (imem_rvalid & outstanding>0): pop the address queue; outstanding -= 1.
  - If drop_cnt>0: discard the response and decrement drop_cnt.
  - Otherwise push {rdata, popped addr} into the buffer.
  - imem_rvalid with outstanding==0 is ignored.
  - Push and pop of the buffer in the same cycle are both honoured.
- p1 register:
  - Priority: reset > (IF_flush | redirect) > id_stall > advance.
  - Flush or redirect: p1 = NOP, p1_valid = 0, p1_pc unchanged.
  - id_stall: hold all p1 outputs.
  - Advance, buffer non-empty: load the head; p1_valid = 1.
  - Advance, buffer empty but a non-dropped response arrives this cycle: load that response directly (bypass); p1_valid = 1.
  - Advance, nothing available: p1 = NOP, p1_valid = 0.
- On redirect:
  - fetch_pc = target.
  - Buffer cleared.
  - drop_cnt = outstanding minus (1 if a response is consumed this cycle).
  - No request is issued that cycle.
  - First fetch from the target starts the next cycle.
- Latency: a bundle granted in cycle t with rvalid in cycle t+k appears on p1 in cycle t+k+1 (bypass, no stall).
- Buffer never overflows by construction; a full buffer with id_stall=1 stops requests.

Test Plan:
- Reset release, gnt=1 always, rvalid one cycle after gnt, rdata = {addr[15:0], ~addr[15:0]}:
  - Required: imem_addr = 0, 4, 8, … back to back.
  - Required: p1_pc = 0 two cycles after the first req, p1_aluInstr = 16'hFFFF, p1_valid = 1, then one bundle per cycle.
- id_stall=1 for 4 cycles during streaming:
  - Required: p1 holds its value; at most 2 more requests are granted before imem_req = 0.
  - Required: after release, bundles resume in order with no address skipped or duplicated.
- Redirect with 2 responses outstanding: pcSrc=01, br_base_pc = 0x100, br_offset = 0x10.
  - Required: p1_valid = 0 the next cycle; both old responses are discarded.
  - Required: next imem_addr = 0x110; first valid p1_pc = 0x110.
- Jump wrap-around: pcSrc=10, jmp_base_pc = 0xFFFF_FFFC, jmp_offset = 4.
  - Required: imem_addr = 0x0000_0000; sequential fetch continues 4, 8.
- IF_flush alone (pcSrc=00) while p1 holds pc 0x8:
  - Required: p1 = NOP, p1_valid = 0 for one cycle.
  - Required: next bundle pc 0xC; fetch_pc unaffected.
- Reset pulsed low with 2 requests outstanding; stale rvalid pulses arrive after release:
  - Required: both ignored; first fetch at RESET_PC; p1_valid = 0 until its response.
